sync_down_counter: RTL

SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

---
 rtl/sync_down_counter_pkg.sv | 24 ++
 rtl/sync_down_counter.sv | 112 +++++++++++
 2 files changed

// File: rtl/sync_down_counter_pkg.sv
// ============================================================================
// Module      : sync_down_counter_pkg
// Description : State encoding and load-clamp helper shared by the counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_down_counter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'b00;
    localparam state_t c_RUN  = 2'b01;
    localparam state_t c_DONE = 2'b10;

    // Out-of-range load values saturate to the top of the legal count range.
    function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                               input logic [31:0] modulus);
        return (value >= modulus) ? (modulus - 32'd1) : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_down_counter.sv
// ============================================================================
// Module      : sync_down_counter
// Description : Modulo down counter with parallel load, auto-reload or
//               one-shot termination, and a borrow strobe for cascading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int width     = 4,
    parameter int max_value = 10
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             enb,
    input  logic             load,
    input  logic [width-1:0] d,
    input  logic             reload,
    output logic [width-1:0] q,
    output logic             cnt_zero,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    generate
        if ((max_value < 2) || (max_value > (2 ** width))) begin : g_param_check
            $error("sync_down_counter: max_value must be in 2..2**width");
        end
    endgenerate

    localparam logic [width-1:0] c_TOP  = width'(max_value - 1);
    localparam logic [width-1:0] c_ONE  = width'(1);
    localparam logic [width-1:0] c_ZERO = '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [width-1:0] r_q;
    logic [width-1:0] w_q_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [width-1:0] w_load_val;
    logic             w_zero;

    assign w_load_val = width'(clamp_load(32'(d), 32'(max_value)));
    assign w_zero     = (r_q == c_ZERO);

    // State, count and done register.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            r_state <= c_IDLE;
            r_q     <= c_ZERO;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state: load beats counting; done pulses on every entry to DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_q_nxt = w_load_val;
            if (w_load_val != c_ZERO) begin
                w_state_nxt = c_RUN;
            end else begin
                w_state_nxt = c_DONE;
                w_done_nxt  = 1'b1;
            end
        end else begin
            case (r_state)
                c_RUN: begin
                    if (enb) begin
                        if (!w_zero) begin
                            w_q_nxt = r_q - c_ONE;
                        end else if (reload) begin
                            w_q_nxt = c_TOP;
                        end else begin
                            w_state_nxt = c_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                c_IDLE, c_DONE: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_q_nxt     = c_ZERO;
                end
            endcase
        end
    end

    // Output decode.
    always_comb begin
        q        = r_q;
        done     = r_done;
        cnt_zero = w_zero;
        busy     = (r_state == c_RUN);
        borrow   = (r_state == c_RUN) && enb && w_zero;
    end

endmodule

`default_nettype wire
